// File: rtl/apb_pkg.sv
// Shared definitions for the APB master: FSM state encoding and the RegFile register map.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

    // RegFile register map (byte-wide register addresses)
    localparam logic [7:0] internal_status_reg = 8'h00;
    localparam logic [7:0] GO_reg              = 8'h01;
    localparam logic [7:0] cent_1_reg          = 8'h02;
    localparam logic [7:0] cent_2_reg          = 8'h03;
    localparam logic [7:0] cent_3_reg          = 8'h04;
    localparam logic [7:0] cent_4_reg          = 8'h05;
    localparam logic [7:0] cent_5_reg          = 8'h06;
    localparam logic [7:0] cent_6_reg          = 8'h07;
    localparam logic [7:0] cent_7_reg          = 8'h08;
    localparam logic [7:0] cent_8_reg          = 8'h09;
    localparam logic [7:0] RAM_addr_reg        = 8'h0A;
    localparam logic [7:0] RAM_data_reg        = 8'h0B;
    localparam logic [7:0] first_ram_addr_reg  = 8'h0C;
    localparam logic [7:0] last_ram_addr_reg   = 8'h0D;

endpackage

// File: rtl/apb_master.sv
// Single-command APB master: takes one command from a sequencer, runs one APB transfer
// with a bounded wait for pready, and returns exactly one response.
module apb_master
    import apb_pkg::*;
#(
    parameter int addrWidth = 8,
    parameter int dataWidth = 91,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [dataWidth-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 psel,
    output logic                 penable,
    output logic                 pwrite,
    output logic [addrWidth-1:0] paddr,
    output logic [dataWidth-1:0] pwdata,
    input  logic [dataWidth-1:0] prdata,
    input  logic                 pready,
    output logic                 busy
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_t           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_write;
    logic [addrWidth-1:0] r_addr;
    logic [dataWidth-1:0] r_wdata;
    logic [dataWidth-1:0] r_rdata;
    logic                 r_err;

    apb_state_t           w_state_next;
    logic [CNT_W-1:0]     w_cnt_next;
    logic                 w_write_next;
    logic [addrWidth-1:0] w_addr_next;
    logic [dataWidth-1:0] w_wdata_next;
    logic [dataWidth-1:0] w_rdata_next;
    logic                 w_err_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_write <= w_write_next;
            r_addr  <= w_addr_next;
            r_wdata <= w_wdata_next;
            r_rdata <= w_rdata_next;
            r_err   <= w_err_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_write_next = r_write;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_rdata_next = r_rdata;
        w_err_next   = r_err;
        unique case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_write_next = cmd_write;
                    w_addr_next  = cmd_addr;
                    w_wdata_next = cmd_wdata;
                    w_state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_cnt_next   = '0;
                w_state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                // pready in the last allowed cycle still completes the transfer normally
                if (pready) begin
                    w_rdata_next = r_write ? '0 : prdata;
                    w_err_next   = 1'b0;
                    w_state_next = ST_RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_rdata_next = '0;
                    w_err_next   = 1'b1;
                    w_state_next = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign psel      = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign penable   = (r_state == ST_ACCESS);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign pwrite    = r_write;
    assign paddr     = r_addr;
    assign pwdata    = r_wdata;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a vector table of single transfers plus reset corner cases.
module tb_apb_master;
    import apb_pkg::*;

    localparam int AW = 8;
    localparam int DW = 91;
    localparam int TO = 16;
    localparam logic [DW-1:0] JUNK = 91'h7AD_BEEF_F00D_CAFE_1357;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          busy;

    always #5 clk = ~clk;

    apb_master #(.addrWidth(AW), .dataWidth(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .busy(busy)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            ws;        // ACCESS cycles with pready=0 before pready=1 (>=TO: never)
        logic [DW-1:0] prd;
        int            hold;      // cycles rsp_ready stays low in RESP
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            exp_lat;   // cycles from handshake edge to rsp_valid
    } vec_t;

    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        int acc;
        int setup_cyc;
        int pen_cyc;
        int rsp_cyc;
        @(posedge clk); #1;
        chk1("cmd_ready_before_cmd", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        // Garbage command held valid while busy must be ignored
        cmd_write = ~v.wr;
        cmd_addr  = 8'hEE;
        cmd_wdata = JUNK;
        cyc = 1; acc = 0; setup_cyc = -1; pen_cyc = -1; rsp_cyc = -1;
        while (rsp_cyc < 0 && cyc <= 40) begin
            if (psel && !penable && setup_cyc < 0) setup_cyc = cyc;
            if (penable && pen_cyc < 0) pen_cyc = cyc;
            if (penable) begin
                chka("paddr_stable", paddr, v.addr);
                chk1("pwrite_stable", pwrite, v.wr);
                if (v.wr) chkd("pwdata_stable", pwdata, v.wdata);
                pready = (acc == v.ws);
                prdata = pready ? v.prd : JUNK;
                acc++;
            end else begin
                pready = 1'b1;
                prdata = JUNK;
            end
            if (rsp_valid) begin
                rsp_cyc = cyc;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        cmd_valid = 1'b0;
        pready    = 1'b1;
        prdata    = JUNK;
        if (rsp_cyc < 0) begin
            chki("rsp_timeout", 0, 1);
        end else begin
            chki("setup_cycle", setup_cyc, 1);
            chki("penable_cycle", pen_cyc, 2);
            chki("rsp_latency", rsp_cyc, v.exp_lat);
            chkd("rsp_rdata", rsp_rdata, v.exp_rdata);
            chk1("rsp_err", rsp_err, v.exp_err);
            chk1("psel_low_in_resp", psel, 1'b0);
            chk1("cmd_ready_low_in_resp", cmd_ready, 1'b0);
            for (int h = 0; h < v.hold; h++) begin
                cmd_valid = 1'b1;
                @(posedge clk); #1;
                chk1("hold_rsp_valid", rsp_valid, 1'b1);
                chkd("hold_rsp_rdata", rsp_rdata, v.exp_rdata);
                chk1("hold_rsp_err", rsp_err, v.exp_err);
                chk1("hold_cmd_ready", cmd_ready, 1'b0);
                chk1("hold_psel", psel, 1'b0);
            end
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            chk1("post_rsp_valid", rsp_valid, 1'b0);
            chk1("post_rsp_busy", busy, 1'b0);
            chk1("post_rsp_cmd_ready", cmd_ready, 1'b1);
            chk1("post_rsp_psel", psel, 1'b0);
        end
        $display("vec %0d: wr=%0b addr=%h ws=%0d lat=%0d err=%0b rdata=%h",
                 idx, v.wr, v.addr, v.ws, rsp_cyc, rsp_err, rsp_rdata);
    endtask

    initial begin
        bit saw_rsp;
        bit got_pen;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; prdata = JUNK; pready = 1'b1;

        vecs[0] = '{wr: 1'b1, addr: GO_reg, wdata: 91'd1, ws: 0, prd: JUNK, hold: 0,
                    exp_rdata: '0, exp_err: 1'b0, exp_lat: 3};
        vecs[1] = '{wr: 1'b0, addr: cent_3_reg, wdata: '0, ws: 3, prd: 91'h5A5A, hold: 0,
                    exp_rdata: 91'h5A5A, exp_err: 1'b0, exp_lat: 6};
        vecs[2] = '{wr: 1'b0, addr: RAM_data_reg, wdata: '0, ws: TO, prd: 91'h1234, hold: 1,
                    exp_rdata: '0, exp_err: 1'b1, exp_lat: 18};
        vecs[3] = '{wr: 1'b0, addr: first_ram_addr_reg, wdata: '0, ws: TO-1, prd: 91'h77, hold: 0,
                    exp_rdata: 91'h77, exp_err: 1'b0, exp_lat: 18};
        vecs[4] = '{wr: 1'b0, addr: cent_1_reg, wdata: '0, ws: 0,
                    prd: 91'h1_2345_6789_ABCD_EF01_2345, hold: 5,
                    exp_rdata: 91'h1_2345_6789_ABCD_EF01_2345, exp_err: 1'b0, exp_lat: 3};
        vecs[5] = '{wr: 1'b1, addr: last_ram_addr_reg, wdata: 91'h3_C0DE_0000_FFFF_1111, ws: 2,
                    prd: 91'h99, hold: 2, exp_rdata: '0, exp_err: 1'b0, exp_lat: 5};
        vecs[6] = '{wr: 1'b1, addr: RAM_addr_reg, wdata: 91'hAB, ws: TO, prd: JUNK, hold: 0,
                    exp_rdata: '0, exp_err: 1'b1, exp_lat: 18};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_psel", psel, 1'b0);
        chk1("rst_penable", penable, 1'b0);
        chk1("rst_pwrite", pwrite, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_rsp_err", rsp_err, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chka("rst_paddr", paddr, '0);
        chkd("rst_pwdata", pwdata, '0);
        chkd("rst_rsp_rdata", rsp_rdata, '0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk1("cmd_ready_after_rst", cmd_ready, 1'b1);
        $display("reset: cmd_ready=%0b busy=%0b", cmd_ready, busy);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset pulsed during ACCESS abandons the transfer
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = cent_4_reg; cmd_wdata = '0;
        @(posedge clk); #1;
        cmd_valid = 1'b0; pready = 1'b0;
        got_pen = 1'b0;
        for (int c = 0; c < 5 && !got_pen; c++) begin
            if (penable) got_pen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk1("midrst_reached_access", got_pen, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk1("midrst_psel", psel, 1'b0);
        chk1("midrst_penable", penable, 1'b0);
        chk1("midrst_rsp_valid", rsp_valid, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chka("midrst_paddr", paddr, '0);
        chkd("midrst_pwdata", pwdata, '0);
        rst = 1'b0;
        pready = 1'b1;
        prdata = JUNK;
        rsp_ready = 1'b1;
        saw_rsp = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (rsp_valid || psel) saw_rsp = 1'b1;
        end
        chk1("midrst_no_response", saw_rsp, 1'b0);
        chk1("midrst_cmd_ready", cmd_ready, 1'b1);
        chkd("midrst_rsp_rdata", rsp_rdata, '0);
        $display("mid-access reset: rsp_seen=%0b cmd_ready=%0b", saw_rsp, cmd_ready);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
